exmem_pipe_reg: RTL and testbench
=================================

Name: exmem_pipe_reg

Overview:
- EX/MEM pipeline register. Captures the EX-stage result, branch/jump decode flags and condition flags every cycle, and presents them to the MEM stage and to the control-hazard detector.
- The detector's redirect output is fed back as `redirect_i`. On a taken redirect, this block squashes the wrong-path instructions that follow, using a shadow counter.
- A squashed instruction becomes a bubble: its valid, RegWr, MemWr and all branch/jump flags are forced to 0.

Parameters:
- DW, 32, datapath width (ALU result, store data, PC values).
- RW, 5, register-index width.
- SHADOW, 3, number of younger instructions squashed after a taken redirect (IF, ID, EX occupants); legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold all register contents; the counter does not advance.
- flush_i  in  1  external flush (exception/debug); inserts one bubble.
- redirect_i  in  1  taken-transfer indication from the control-hazard detector (combinational from this block's outputs).
- ex_valid_i  in  1  EX occupant is a real instruction.
- ex_ctrl_i  in  12  {Jump, Jal, Jalr, Beq, Bne, Bgez, Bgtz, Blez, Bltz, RegWr, MemWr, MemtoReg}.
- ex_flags_i  in  3  {Zero, ZBgez, ZBgtz}.
- ex_alu_i  in  DW  ALU result.
- ex_wdata_i  in  DW  store data.
- ex_rd_i  in  RW  destination register.
- ex_target_i  in  DW  branch/jump target.
- ex_pc4_i  in  DW  PC+4 (link value).
- mem_valid_o  out  1  MEM occupant valid.
- mem_ctrl_o  out  12  latched control, same bit order.
- mem_flags_o  out  3  latched flags.
- mem_alu_o, mem_wdata_o, mem_target_o, mem_pc4_o  out  DW  latched data.
- mem_rd_o  out  RW  latched destination.
- shadow_busy_o  out  1  squash window active (shadow_cnt != 0).

Behaviour:
- Reset (async, rst_n=0): all outputs 0; shadow_cnt=0. Takes effect immediately, including mid-squash. Release is sampled on the next rising edge.
- Latency: one cycle, EX inputs to MEM outputs.
- Each rising edge, priority is: reset > stall > squash > normal load.
- stall_i=1: every register holds. shadow_cnt holds. redirect_i is ignored, because the MEM occupant is unchanged and its redirect was already counted.
- Squash condition: flush_i, or redirect_i, or shadow_cnt!=0. On squash:
  - mem_valid_o, RegWr, MemWr, MemtoReg and all 9 branch/jump bits load 0.
  - Data fields load their inputs; they are don't-care but must be deterministic.
- Normal load: all fields load from their inputs. mem_valid_o = ex_valid_i. Control bits are ANDed with ex_valid_i, so an invalid EX occupant never writes.
- Shadow counter (3 bits):
  - redirect_i=1 and not stalled: shadow_cnt <= SHADOW-1. The same edge squashes the EX occupant, so SHADOW instructions are squashed in total.
  - Else if shadow_cnt!=0 and not stalled: decrement.
  - A redirect arriving while shadow_cnt!=0 cannot happen, because squashed entries carry no branch bits. If it does arrive, it reloads the counter (defensive).
- flush_i does not touch shadow_cnt.
- Simultaneous flush_i and redirect_i: squash, and load the counter.
- redirect_i is combinational from mem_* outputs, so the block must not create a combinational path from redirect_i to mem_* outputs.

Optional Feature:
- Macro EXMEM_SQUASH_STATS_EN.
- When defined: adds output squash_cnt_o [15:0]. It increments on each non-stalled edge where a valid EX occupant (ex_valid_i=1) is squashed, and saturates at 16'hFFFF. Reset value 0.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - bit-index constants for ex_ctrl_i (CTL_JUMP=11 … CTL_MEMTOREG=0) and ex_flags_i (FLG_ZERO=2, FLG_ZBGEZ=1, FLG_ZBGTZ=0);
  - CTRL_W=12 and FLAG_W=3;
  - default SHADOW.
- One natural sub-module: squash_shadow_ctr (counter plus squash decision). The datapath register stays in the top.

Test Plan:
- Reset mid-window: redirect, then rst_n low one cycle later → all outputs 0 immediately; after release, the next valid instruction passes.
- Normal flow: ex_valid_i=1, RegWr=1, ex_alu_i=32'h1234 → next cycle mem_valid_o=1, mem_alu_o=32'h1234, shadow_busy_o=0.
- Taken beq: latch Beq=1, Zero=1, and the detector model drives redirect_i=1 → the next 3 valid instructions (SHADOW=3) appear with mem_valid_o=0, RegWr=0, MemWr=0; the 4th passes.
- Stall inside window: redirect, then stall_i=1 for 2 cycles after the first squash → outputs hold and the counter does not advance; exactly 3 squashed instructions total.
- Flush plus invalid: flush_i=1 with MemWr=1 → bubble. Also ex_valid_i=0 with RegWr=1 → mem_ctrl_o RegWr=0.
- With EXMEM_SQUASH_STATS_EN: 2 taken redirects → squash_cnt_o=6. Preload near 16'hFFFF → saturates.

Source files
------------

// File: rtl/exmem_pipe_reg_pkg.sv
// rtl/exmem_pipe_reg_pkg.sv - shared constants and helpers for the EX/MEM pipeline register
//
// Purpose : bit positions of the control and flag vectors carried from EX to
//           MEM, their widths, the shadow-counter width and the default squash
//           depth. Also holds a small gating helper used by the datapath.
// Ports   : none (package).

package exmem_pipe_reg_pkg;

  localparam int CTRL_W = 12;
  localparam int FLAG_W = 3;

  // ex_ctrl_i / mem_ctrl_o bit positions
  localparam int CTL_JUMP     = 11;
  localparam int CTL_JAL      = 10;
  localparam int CTL_JALR     = 9;
  localparam int CTL_BEQ      = 8;
  localparam int CTL_BNE      = 7;
  localparam int CTL_BGEZ     = 6;
  localparam int CTL_BGTZ     = 5;
  localparam int CTL_BLEZ     = 4;
  localparam int CTL_BLTZ     = 3;
  localparam int CTL_REGWR    = 2;
  localparam int CTL_MEMWR    = 1;
  localparam int CTL_MEMTOREG = 0;

  // ex_flags_i / mem_flags_o bit positions
  localparam int FLG_ZERO  = 2;
  localparam int FLG_ZBGEZ = 1;
  localparam int FLG_ZBGTZ = 0;

  // Squash window: three younger instructions (IF, ID, EX occupants).
  localparam int SHADOW_DEF = 3;
  localparam int CNT_W      = 3;

  localparam int STATS_W = 16;

  // Pass the control vector through only when keep is set; a bubble must
  // never write a register, write memory or request a branch.
  function automatic logic [CTRL_W-1:0] ctrl_gate(input logic [CTRL_W-1:0] ctrl,
                                                  input logic              keep);
    return keep ? ctrl : '0;
  endfunction

endpackage

// File: rtl/exmem_pipe_reg_squash_shadow_ctr.sv
// rtl/exmem_pipe_reg_squash_shadow_ctr.sv - wrong-path shadow counter and squash decision
//
// Purpose : counts down the wrong-path instructions that follow a taken
//           redirect and decides whether the instruction leaving EX this
//           cycle must become a bubble.
// Ports   : clk, rst_n      clock, async active-low reset
//           stall_i         freeze the counter
//           flush_i         external one-bubble flush (does not touch counter)
//           redirect_i      taken transfer seen on the MEM occupant
//           squash_o        squash the EX occupant on the coming edge
//           busy_o          squash window active (counter non-zero)

module squash_shadow_ctr
  import exmem_pipe_reg_pkg::*;
#(
  parameter int SHADOW = SHADOW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  input  logic flush_i,
  input  logic redirect_i,
  output logic squash_o,
  output logic busy_o
);

  // The redirecting edge itself squashes one instruction, so the counter only
  // has to cover the remaining SHADOW-1.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SHADOW - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_nz;

  assign cnt_nz = (cnt_q != '0);

  // squash_o only feeds register D inputs in the top, so the combinational
  // redirect_i dependency never reaches a mem_* output.
  assign squash_o = flush_i | redirect_i | cnt_nz;
  assign busy_o   = cnt_nz;

  always_comb begin
    cnt_d = cnt_q;
    if (!stall_i) begin
      // A redirect while the window is open is not expected (bubbles carry no
      // branch bits); reloading is the safe reaction if it ever occurs.
      if (redirect_i) begin
        cnt_d = RELOAD;
      end else if (cnt_nz) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exmem_pipe_reg.sv
// rtl/exmem_pipe_reg.sv - EX/MEM pipeline register with redirect squash window
//
// Purpose : latches the EX-stage result, control and condition flags for the
//           MEM stage, turning wrong-path and flushed instructions into bubbles.
//           Optional macro EXMEM_SQUASH_STATS_EN adds a saturating count of
//           squashed valid instructions on squash_cnt_o.
// Ports   : clk, rst_n                 clock, async active-low reset
//           stall_i, flush_i           hold everything / insert one bubble
//           redirect_i                 taken transfer from the hazard detector
//           ex_valid_i .. ex_pc4_i     EX-stage occupant
//           mem_valid_o .. mem_rd_o    MEM-stage occupant (one cycle later)
//           shadow_busy_o              squash window active
//           squash_cnt_o               squashed-valid count (macro only)

module exmem_pipe_reg
  import exmem_pipe_reg_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int SHADOW = SHADOW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic              ex_valid_i,
  input  logic [CTRL_W-1:0] ex_ctrl_i,
  input  logic [FLAG_W-1:0] ex_flags_i,
  input  logic [DW-1:0]     ex_alu_i,
  input  logic [DW-1:0]     ex_wdata_i,
  input  logic [RW-1:0]     ex_rd_i,
  input  logic [DW-1:0]     ex_target_i,
  input  logic [DW-1:0]     ex_pc4_i,
  output logic              mem_valid_o,
  output logic [CTRL_W-1:0] mem_ctrl_o,
  output logic [FLAG_W-1:0] mem_flags_o,
  output logic [DW-1:0]     mem_alu_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [DW-1:0]     mem_target_o,
  output logic [DW-1:0]     mem_pc4_o,
  output logic [RW-1:0]     mem_rd_o,
  output logic              shadow_busy_o
`ifdef EXMEM_SQUASH_STATS_EN
  ,
  output logic [STATS_W-1:0] squash_cnt_o
`endif
);

  logic squash;

  squash_shadow_ctr #(
    .SHADOW (SHADOW)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .redirect_i (redirect_i),
    .squash_o   (squash),
    .busy_o     (shadow_busy_o)
  );

  logic              valid_q,  valid_d;
  logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
  logic [FLAG_W-1:0] flags_q,  flags_d;
  logic [DW-1:0]     alu_q,    alu_d;
  logic [DW-1:0]     wdata_q,  wdata_d;
  logic [DW-1:0]     target_q, target_d;
  logic [DW-1:0]     pc4_q,    pc4_d;
  logic [RW-1:0]     rd_q,     rd_d;

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    flags_d  = flags_q;
    alu_d    = alu_q;
    wdata_d  = wdata_q;
    target_d = target_q;
    pc4_d    = pc4_q;
    rd_d     = rd_q;
    if (!stall_i) begin
      // Data and flags always follow EX so a bubble is still deterministic;
      // only valid and control are what make it harmless.
      flags_d  = ex_flags_i;
      alu_d    = ex_alu_i;
      wdata_d  = ex_wdata_i;
      target_d = ex_target_i;
      pc4_d    = ex_pc4_i;
      rd_d     = ex_rd_i;
      valid_d  = ex_valid_i & ~squash;
      ctrl_d   = ctrl_gate(ex_ctrl_i, ex_valid_i & ~squash);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      flags_q  <= '0;
      alu_q    <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      pc4_q    <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      flags_q  <= flags_d;
      alu_q    <= alu_d;
      wdata_q  <= wdata_d;
      target_q <= target_d;
      pc4_q    <= pc4_d;
      rd_q     <= rd_d;
    end
  end

  assign mem_valid_o  = valid_q;
  assign mem_ctrl_o   = ctrl_q;
  assign mem_flags_o  = flags_q;
  assign mem_alu_o    = alu_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_target_o = target_q;
  assign mem_pc4_o    = pc4_q;
  assign mem_rd_o     = rd_q;

`ifdef EXMEM_SQUASH_STATS_EN
  localparam logic [STATS_W-1:0] STATS_MAX = '1;

  logic [STATS_W-1:0] stats_q, stats_d;

  always_comb begin
    stats_d = stats_q;
    if (!stall_i && squash && ex_valid_i && (stats_q != STATS_MAX)) begin
      stats_d = stats_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign squash_cnt_o = stats_q;
`endif

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// tb/tb_exmem_pipe_reg.sv - directed self-checking bench for exmem_pipe_reg
//
// Purpose : drives directed EX-stage vectors, models the control-hazard
//           detector that closes the redirect loop, and checks MEM outputs.
//           Build with EXMEM_SQUASH_STATS_EN to also check squash_cnt_o.
// Ports   : none (top-level bench).

module tb_exmem_pipe_reg;
  import exmem_pipe_reg_pkg::*;

  localparam logic [11:0] C_REGWR = 12'h004;
  localparam logic [11:0] C_MEMWR = 12'h002;
  localparam logic [11:0] C_BEQ   = 12'h100;
  localparam logic [2:0]  F_ZERO  = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, redirect_i;
  logic        ex_valid_i;
  logic [11:0] ex_ctrl_i;
  logic [2:0]  ex_flags_i;
  logic [31:0] ex_alu_i, ex_wdata_i, ex_target_i, ex_pc4_i;
  logic [4:0]  ex_rd_i;
  logic        mem_valid_o;
  logic [11:0] mem_ctrl_o;
  logic [2:0]  mem_flags_o;
  logic [31:0] mem_alu_o, mem_wdata_o, mem_target_o, mem_pc4_o;
  logic [4:0]  mem_rd_o;
  logic        shadow_busy_o;
`ifdef EXMEM_SQUASH_STATS_EN
  logic [15:0] squash_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Hazard detector model: unconditional jumps, beq taken on Zero, bne on !Zero.
  assign redirect_i = mem_ctrl_o[CTL_JUMP] | mem_ctrl_o[CTL_JAL] | mem_ctrl_o[CTL_JALR]
                    | (mem_ctrl_o[CTL_BEQ] & mem_flags_o[FLG_ZERO])
                    | (mem_ctrl_o[CTL_BNE] & ~mem_flags_o[FLG_ZERO]);

  exmem_pipe_reg dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .ex_valid_i    (ex_valid_i),
    .ex_ctrl_i     (ex_ctrl_i),
    .ex_flags_i    (ex_flags_i),
    .ex_alu_i      (ex_alu_i),
    .ex_wdata_i    (ex_wdata_i),
    .ex_rd_i       (ex_rd_i),
    .ex_target_i   (ex_target_i),
    .ex_pc4_i      (ex_pc4_i),
    .mem_valid_o   (mem_valid_o),
    .mem_ctrl_o    (mem_ctrl_o),
    .mem_flags_o   (mem_flags_o),
    .mem_alu_o     (mem_alu_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_target_o  (mem_target_o),
    .mem_pc4_o     (mem_pc4_o),
    .mem_rd_o      (mem_rd_o),
    .shadow_busy_o (shadow_busy_o)
`ifdef EXMEM_SQUASH_STATS_EN
    ,
    .squash_cnt_o  (squash_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] c, input logic [2:0] f,
                       input logic [31:0] alu);
    ex_valid_i  = v;
    ex_ctrl_i   = c;
    ex_flags_i  = f;
    ex_alu_i    = alu;
    ex_wdata_i  = alu ^ 32'hA5A5_0000;
    ex_target_i = alu + 32'h40;
    ex_pc4_i    = alu + 32'h4;
    ex_rd_i     = alu[4:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input string tag, input logic v, input logic [11:0] c,
                         input logic [31:0] alu, input logic busy);
    chk({tag, ".valid"}, 64'(mem_valid_o), 64'(v));
    chk({tag, ".ctrl"},  64'(mem_ctrl_o),  64'(c));
    chk({tag, ".alu"},   64'(mem_alu_o),   64'(alu));
    chk({tag, ".busy"},  64'(shadow_busy_o), 64'(busy));
  endtask

  initial begin
    rst_n   = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(1'b1, 12'hFFF, 3'b111, 32'hDEAD_BEEF);

    // Reset state, even with non-zero inputs present at the edge.
    step();
    chk_mem("rst", 1'b0, 12'h000, 32'h0, 1'b0);
    chk("rst.wdata", 64'(mem_wdata_o), 64'h0);
    chk("rst.pc4",   64'(mem_pc4_o),   64'h0);
    chk("rst.rd",    64'(mem_rd_o),    64'h0);
`ifdef EXMEM_SQUASH_STATS_EN
    chk("rst.stats", 64'(squash_cnt_o), 64'h0);
`endif
    rst_n = 1'b1;

    // Normal flow.
    drive(1'b1, C_REGWR, 3'b000, 32'h1234);
    step();
    chk_mem("norm", 1'b1, C_REGWR, 32'h1234, 1'b0);
    chk("norm.wdata",  64'(mem_wdata_o),  64'hA5A5_1234);
    chk("norm.target", 64'(mem_target_o), 64'h1274);
    chk("norm.pc4",    64'(mem_pc4_o),    64'h1238);
    chk("norm.rd",     64'(mem_rd_o),     64'h14);

    // Invalid EX occupant never writes.
    drive(1'b0, C_REGWR, 3'b000, 32'h2000);
    step();
    chk_mem("inval", 1'b0, 12'h000, 32'h2000, 1'b0);

    // External flush turns a store into a bubble, no window opened.
    drive(1'b1, C_MEMWR, 3'b000, 32'h3000);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk_mem("flush", 1'b0, 12'h000, 32'h3000, 1'b0);

    // Taken beq: three younger instructions squashed, fourth passes.
    drive(1'b1, C_BEQ, F_ZERO, 32'h4000);
    step();
    chk_mem("beq.mem", 1'b1, C_BEQ, 32'h4000, 1'b0);
    chk("beq.flags", 64'(mem_flags_o), 64'(F_ZERO));
    drive(1'b1, C_REGWR | C_MEMWR, 3'b000, 32'h4001);
    step();
    chk_mem("beq.sq1", 1'b0, 12'h000, 32'h4001, 1'b1);
    drive(1'b1, C_REGWR, 3'b000, 32'h4002);
    step();
    chk_mem("beq.sq2", 1'b0, 12'h000, 32'h4002, 1'b1);
    drive(1'b1, C_REGWR, 3'b000, 32'h4003);
    step();
    chk_mem("beq.sq3", 1'b0, 12'h000, 32'h4003, 1'b0);
    drive(1'b1, C_REGWR, 3'b000, 32'h4004);
    step();
    chk_mem("beq.pass", 1'b1, C_REGWR, 32'h4004, 1'b0);

    // Stall for two cycles after the first squash.
    drive(1'b1, C_BEQ, F_ZERO, 32'h5000);
    step();
    drive(1'b1, C_REGWR, 3'b000, 32'h5001);
    step();
    chk_mem("stw.sq1", 1'b0, 12'h000, 32'h5001, 1'b1);
    drive(1'b1, C_REGWR, 3'b000, 32'h5002);
    stall_i = 1'b1;
    step();
    chk_mem("stw.hold1", 1'b0, 12'h000, 32'h5001, 1'b1);
    step();
    chk_mem("stw.hold2", 1'b0, 12'h000, 32'h5001, 1'b1);
    stall_i = 1'b0;
    step();
    chk_mem("stw.sq2", 1'b0, 12'h000, 32'h5002, 1'b1);
    drive(1'b1, C_REGWR, 3'b000, 32'h5003);
    step();
    chk_mem("stw.sq3", 1'b0, 12'h000, 32'h5003, 1'b0);
    drive(1'b1, C_REGWR, 3'b000, 32'h5004);
    step();
    chk_mem("stw.pass", 1'b1, C_REGWR, 32'h5004, 1'b0);

    // Stall while the taken branch sits in MEM: redirect is ignored while held.
    drive(1'b1, C_BEQ, F_ZERO, 32'h6000);
    step();
    drive(1'b1, C_REGWR, 3'b000, 32'h6001);
    stall_i = 1'b1;
    step();
    chk_mem("stb.hold", 1'b1, C_BEQ, 32'h6000, 1'b0);
    stall_i = 1'b0;
    step();
    chk_mem("stb.sq1", 1'b0, 12'h000, 32'h6001, 1'b1);
    drive(1'b1, C_REGWR, 3'b000, 32'h6002);
    step();
    chk_mem("stb.sq2", 1'b0, 12'h000, 32'h6002, 1'b1);
    drive(1'b1, C_REGWR, 3'b000, 32'h6003);
    step();
    chk_mem("stb.sq3", 1'b0, 12'h000, 32'h6003, 1'b0);
    drive(1'b1, C_REGWR, 3'b000, 32'h6004);
    step();
    chk_mem("stb.pass", 1'b1, C_REGWR, 32'h6004, 1'b0);

    // Reset in the middle of a squash window takes effect immediately.
    drive(1'b1, C_BEQ, F_ZERO, 32'h7000);
    step();
    drive(1'b1, C_REGWR, 3'b000, 32'h7001);
    step();
    chk_mem("rmw.sq1", 1'b0, 12'h000, 32'h7001, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_mem("rmw.async", 1'b0, 12'h000, 32'h0, 1'b0);
    chk("rmw.flags", 64'(mem_flags_o), 64'h0);
    step();
    rst_n = 1'b1;
    drive(1'b1, C_REGWR, 3'b000, 32'h7777);
    step();
    chk_mem("rmw.pass", 1'b1, C_REGWR, 32'h7777, 1'b0);

`ifdef EXMEM_SQUASH_STATS_EN
    chk("stats.zero", 64'(squash_cnt_o), 64'h0);
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, C_BEQ, F_ZERO, 32'h8000);
      step();
      for (int k = 0; k < 4; k++) begin
        drive(1'b1, C_REGWR, 3'b000, 32'h8100 + 32'(k));
        step();
      end
    end
    chk("stats.two_redirects", 64'(squash_cnt_o), 64'd6);
    drive(1'b1, C_REGWR, 3'b000, 32'h9000);
    flush_i = 1'b1;
    for (int k = 0; k < 65535; k++) begin
      step();
    end
    flush_i = 1'b0;
    chk("stats.saturate", 64'(squash_cnt_o), 64'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
